// File: rtl/mcu_pixel_serializer.sv
`default_nettype none
// ============================================================================
// mcu_pixel_serializer: ping-pong buffers 8x8 RGB blocks and replays them as a
// clipped, (x,y)-tagged valid/ready pixel stream in 4:2:0 MCU order. Rev 1.0
// ============================================================================
module mcu_pixel_serializer #(
    parameter int DIM_W = 16,
    parameter int NBUF  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DIM_W-1:0]     img_width,
    input  logic [DIM_W-1:0]     img_height,
    input  logic [7:0][7:0][7:0] r,
    input  logic [7:0][7:0][7:0] g,
    input  logic [7:0][7:0][7:0] b,
    input  logic                 valid_in,
    input  logic                 pix_ready,
    output logic                 pix_valid,
    output logic [7:0]           pix_r,
    output logic [7:0]           pix_g,
    output logic [7:0]           pix_b,
    output logic [DIM_W-1:0]     pix_x,
    output logic [DIM_W-1:0]     pix_y,
    output logic                 blk_full,
    output logic                 overflow,
    output logic                 frame_done
);
    localparam int KW    = 2 * DIM_W;
    localparam int CNT_W = $clog2(NBUF + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [DIM_W-1:0]       r_w, r_h, r_mw, r_mx, r_mox, r_moy;
    logic [KW-1:0]          r_total, r_k;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_wp, r_rp;
    logic [5:0]             r_p;
    logic [7:0][7:0][7:0]   r_br [NBUF];
    logic [7:0][7:0][7:0]   r_bg [NBUF];
    logic [7:0][7:0][7:0]   r_bb [NBUF];

    logic [DIM_W-1:0] w_mw, w_mt;
    logic [KW-1:0]    w_prod, w_total, w_k1;
    logic             w_start_ok, w_armed, w_cap, w_drop, w_retire, w_last;
    logic             w_fdone, w_chain, w_begin, w_load, w_ld_buf, w_ld_in;
    logic             w_mcu_end, w_row_end;
    logic [1:0]       w_q, w_nq;
    logic [DIM_W-1:0] w_n_mx, w_n_mox, w_n_moy, w_c_ox, w_c_oy, w_n_ox, w_n_oy;
    logic [DIM_W-1:0] w_ld_ox, w_ld_oy;
    logic [DIM_W:0]   w_ld_x, w_ld_y;
    logic [5:0]       w_ld_p;
    logic [CNT_W-1:0] w_cnt_nx;

    // Frame geometry: ceil(dim/16) MCUs each way, four 8x8 blocks per MCU.
    assign w_mw       = DIM_W'(({1'b0, img_width}  + (DIM_W+1)'(15)) >> 4);
    assign w_mt       = DIM_W'(({1'b0, img_height} + (DIM_W+1)'(15)) >> 4);
    assign w_prod     = KW'(w_mw) * KW'(w_mt);
    assign w_total    = w_prod << 2;
    assign w_start_ok = start && (img_width != '0) && (img_height != '0);

    assign w_armed  = (r_state == S_ARMED) || (r_state == S_EMIT);
    assign w_cap    = valid_in && w_armed && (r_cnt != CNT_W'(NBUF));
    assign w_drop   = valid_in && !w_cap;
    assign w_retire = (r_state == S_EMIT) && (!pix_valid || pix_ready);
    assign w_last   = w_retire && (r_p == 6'd63);
    assign w_k1     = r_k + KW'(1);
    assign w_fdone  = w_last && (w_k1 == r_total);
    assign w_chain  = w_last && !w_fdone && (r_cnt == CNT_W'(NBUF));
    assign w_begin  = (r_state == S_ARMED) && (r_cnt != '0);
    assign w_load   = w_begin || (w_retire && !w_last) || w_chain;

    // Placement walks MCU columns with a counter; no division needed.
    assign w_q       = r_k[1:0];
    assign w_nq      = w_q + 2'd1;
    assign w_mcu_end = (w_q == 2'd3);
    assign w_row_end = ((r_mx + DIM_W'(1)) == r_mw);
    assign w_n_mx    = w_mcu_end ? (w_row_end ? '0 : r_mx + DIM_W'(1)) : r_mx;
    assign w_n_mox   = w_mcu_end ? (w_row_end ? '0 : r_mox + DIM_W'(16)) : r_mox;
    assign w_n_moy   = (w_mcu_end && w_row_end) ? r_moy + DIM_W'(16) : r_moy;
    assign w_c_ox    = r_mox   + {{(DIM_W-4){1'b0}}, w_q[0],  3'b000};
    assign w_c_oy    = r_moy   + {{(DIM_W-4){1'b0}}, w_q[1],  3'b000};
    assign w_n_ox    = w_n_mox + {{(DIM_W-4){1'b0}}, w_nq[0], 3'b000};
    assign w_n_oy    = w_n_moy + {{(DIM_W-4){1'b0}}, w_nq[1], 3'b000};

    assign w_ld_p   = (w_retire && !w_last) ? r_p + 6'd1 : 6'd0;
    assign w_ld_buf = w_chain ? ~r_rp : r_rp;
    assign w_ld_ox  = w_chain ? w_n_ox : w_c_ox;
    assign w_ld_oy  = w_chain ? w_n_oy : w_c_oy;
    // One extra bit keeps origin+7 from wrapping past the clip compare.
    assign w_ld_x   = {1'b0, w_ld_ox} + {{(DIM_W-2){1'b0}}, w_ld_p[2:0]};
    assign w_ld_y   = {1'b0, w_ld_oy} + {{(DIM_W-2){1'b0}}, w_ld_p[5:3]};
    assign w_ld_in  = (w_ld_x < {1'b0, r_w}) && (w_ld_y < {1'b0, r_h});

    always_comb begin
        w_cnt_nx = r_cnt;
        if (w_cap && !w_last)
            w_cnt_nx = r_cnt + CNT_W'(1);
        else if (!w_cap && w_last)
            w_cnt_nx = r_cnt - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (w_cap) begin
            r_br[r_wp] <= r;
            r_bg[r_wp] <= g;
            r_bb[r_wp] <= b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_w <= '0; r_h <= '0; r_mw <= '0; r_total <= '0; r_k <= '0;
            r_mx <= '0; r_mox <= '0; r_moy <= '0; r_cnt <= '0;
            r_wp <= 1'b0; r_rp <= 1'b0; r_p <= '0;
            pix_valid <= 1'b0; pix_r <= '0; pix_g <= '0; pix_b <= '0;
            pix_x <= '0; pix_y <= '0;
            blk_full <= 1'b0; overflow <= 1'b0; frame_done <= 1'b0;
        end else if (w_start_ok) begin
            r_state <= S_ARMED;
            r_w <= img_width; r_h <= img_height; r_mw <= w_mw; r_total <= w_total;
            r_k <= '0; r_mx <= '0; r_mox <= '0; r_moy <= '0; r_cnt <= '0;
            r_wp <= 1'b0; r_rp <= 1'b0; r_p <= '0;
            pix_valid <= 1'b0; blk_full <= 1'b0; overflow <= 1'b0; frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (w_drop)
                overflow <= 1'b1;
            r_cnt    <= w_cnt_nx;
            blk_full <= (w_cnt_nx == CNT_W'(NBUF));
            if (w_cap)
                r_wp <= ~r_wp;
            if (w_load) begin
                r_p       <= w_ld_p;
                pix_valid <= w_ld_in;
                pix_x     <= w_ld_x[DIM_W-1:0];
                pix_y     <= w_ld_y[DIM_W-1:0];
                pix_r     <= r_br[w_ld_buf][w_ld_p[5:3]][w_ld_p[2:0]];
                pix_g     <= r_bg[w_ld_buf][w_ld_p[5:3]][w_ld_p[2:0]];
                pix_b     <= r_bb[w_ld_buf][w_ld_p[5:3]][w_ld_p[2:0]];
            end
            case (r_state)
                S_ARMED: if (w_begin) r_state <= S_EMIT;
                S_EMIT: if (w_last) begin
                    r_k   <= w_k1;
                    r_mx  <= w_n_mx;
                    r_mox <= w_n_mox;
                    r_moy <= w_n_moy;
                    r_rp  <= ~r_rp;
                    if (w_fdone) begin
                        r_state    <= S_DONE;
                        frame_done <= 1'b1;
                        pix_valid  <= 1'b0;
                        r_cnt      <= '0;
                        blk_full   <= 1'b0;
                        r_wp       <= 1'b0;
                        r_rp       <= 1'b0;
                    end else if (!w_chain) begin
                        r_state   <= S_ARMED;
                        pix_valid <= 1'b0;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mcu_pixel_serializer.sv
`default_nettype none
// tb_mcu_pixel_serializer: frame scenarios from a vector table plus corner sequences;
// expected pixels come from an independent placement model through a scoreboard.
module tb_mcu_pixel_serializer;
    typedef logic [7:0][7:0][7:0] blk_t;
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } pix_t;
    typedef struct {
        int w; int h; int nblk; int gap; int exp_pix; int exp_fd; bit exp_ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, start, valid_in, pix_ready;
    logic [15:0] img_width, img_height;
    blk_t        r_in, g_in, b_in;
    logic        pix_valid, blk_full, overflow, frame_done;
    logic [7:0]  pix_r, pix_g, pix_b;
    logic [15:0] pix_x, pix_y;

    int   checks = 0, errors = 0, pix_cnt = 0, fd_cnt = 0, rdy_mode = 0, cyc = 0;
    pix_t sb[$];
    pix_t cur, prev, exp_p;
    bit   prev_stall = 0;
    vec_t vt[4];

    mcu_pixel_serializer #(.DIM_W(16), .NBUF(2)) dut (
        .clk(clk), .rst(rst), .start(start),
        .img_width(img_width), .img_height(img_height),
        .r(r_in), .g(g_in), .b(b_in), .valid_in(valid_in),
        .pix_ready(pix_ready), .pix_valid(pix_valid),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .pix_x(pix_x), .pix_y(pix_y),
        .blk_full(blk_full), .overflow(overflow), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            cyc++;
            pix_ready = (rdy_mode == 0) || (cyc % 3 == 0);
        end
    end

    // Output monitor: pops the scoreboard on every accepted pixel.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            cur = {pix_x, pix_y, pix_r, pix_g, pix_b};
            if (prev_stall)
                chk(pix_valid === 1'b1 && cur === prev, "stall_hold", cur, prev);
            if (pix_valid && pix_ready) begin
                pix_cnt++;
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_pixel", cur, 0);
                end else begin
                    exp_p = sb.pop_front();
                    chk(cur === exp_p, "pixel", cur, exp_p);
                end
            end
            if (frame_done) fd_cnt++;
            prev_stall = pix_valid && !pix_ready;
            prev = cur;
        end
    end

    task automatic push_block(input int k, input int w, input int h);
        int mw, m, q, ox, oy, x, y;
        pix_t p;
        mw = (w + 15) / 16; m = k / 4; q = k % 4;
        ox = (m % mw) * 16 + (q % 2) * 8;
        oy = (m / mw) * 16 + (q / 2) * 8;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                x = ox + j; y = oy + i;
                if (x < w && y < h) begin
                    p.x = 16'(x); p.y = 16'(y);
                    p.r = r_in[i][j]; p.g = g_in[i][j]; p.b = b_in[i][j];
                    sb.push_back(p);
                end
            end
        end
    endtask

    task automatic drive_block(input bit accepted, input int k, input int w, input int h);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                r_in[i][j] = 8'($urandom);
                g_in[i][j] = 8'($urandom);
                b_in[i][j] = 8'($urandom);
            end
        end
        if (accepted) push_block(k, w, h);
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete(); pix_cnt = 0; fd_cnt = 0;
    endtask

    task automatic do_start(input int w, input int h);
        img_width = 16'(w); img_height = 16'(h); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_drain(input int limit, input string name);
        for (int n = 0; n < limit && sb.size() != 0; n++) @(posedge clk);
        #1;
        chk(sb.size() == 0, name, sb.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string name);
        chk({pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, blk_full, overflow, frame_done} == '0,
            name, {pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, blk_full, overflow, frame_done}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; valid_in = 1'b0;
        img_width = '0; img_height = '0;
        r_in = '0; g_in = '0; b_in = '0;
        vt[0] = '{w:16, h:16, nblk:4,  gap:100, exp_pix:256, exp_fd:1, exp_ovf:0};
        vt[1] = '{w:20, h:10, nblk:8,  gap:70,  exp_pix:200, exp_fd:1, exp_ovf:0};
        vt[2] = '{w:24, h:24, nblk:16, gap:70,  exp_pix:576, exp_fd:1, exp_ovf:0};
        vt[3] = '{w:7,  h:5,  nblk:4,  gap:70,  exp_pix:35,  exp_fd:1, exp_ovf:0};
        @(posedge clk); #1;

        for (int t = 0; t < 4; t++) begin
            do_reset();
            chk_zero($sformatf("t%0d_reset_state", t));
            do_start(vt[t].w, vt[t].h);
            for (int k = 0; k < vt[t].nblk; k++) begin
                drive_block(1'b1, k, vt[t].w, vt[t].h);
                repeat (vt[t].gap) @(posedge clk);
                #1;
            end
            wait_drain(300, $sformatf("t%0d_drain", t));
            chk(pix_cnt == vt[t].exp_pix, $sformatf("t%0d_pix_count", t), pix_cnt, vt[t].exp_pix);
            chk(fd_cnt == vt[t].exp_fd, $sformatf("t%0d_frame_done", t), fd_cnt, vt[t].exp_fd);
            chk(overflow == vt[t].exp_ovf, $sformatf("t%0d_overflow", t), overflow, vt[t].exp_ovf);
        end

        // Latency, then a mid-frame restart.
        do_reset();
        do_start(32, 16);
        drive_block(1'b1, 0, 32, 16);
        @(negedge clk);
        chk(pix_valid == 1'b0, "latency_early", pix_valid, 0);
        @(negedge clk);
        chk(pix_valid == 1'b1 && pix_x == 0 && pix_y == 0, "latency_first",
            {pix_valid, pix_x, pix_y}, {1'b1, 32'd0});
        @(posedge clk); #1;
        repeat (70) @(posedge clk);
        #1;
        for (int k = 1; k < 3; k++) begin
            drive_block(1'b1, k, 32, 16);
            repeat (70) @(posedge clk);
            #1;
        end
        do_start(16, 16);
        repeat (3) @(posedge clk);
        #1;
        chk(fd_cnt == 0, "restart_no_frame_done", fd_cnt, 0);
        for (int k = 0; k < 4; k++) begin
            drive_block(1'b1, k, 16, 16);
            repeat (70) @(posedge clk);
            #1;
        end
        wait_drain(300, "restart_drain");
        chk(pix_cnt == 448, "restart_pix_count", pix_cnt, 448);
        chk(fd_cnt == 1, "restart_frame_done", fd_cnt, 1);

        // Backpressure with three back-to-back blocks.
        do_reset();
        do_start(16, 16);
        rdy_mode = 1;
        drive_block(1'b1, 0, 16, 16);
        drive_block(1'b1, 1, 16, 16);
        chk(blk_full == 1'b1, "bp_blk_full", blk_full, 1);
        drive_block(1'b0, 2, 16, 16);
        chk(overflow == 1'b1, "bp_overflow", overflow, 1);
        wait_drain(1000, "bp_drain");
        rdy_mode = 0;
        chk(pix_cnt == 128, "bp_pix_count", pix_cnt, 128);
        chk(blk_full == 1'b0, "bp_blk_empty", blk_full, 0);
        chk(fd_cnt == 0, "bp_frame_done", fd_cnt, 0);

        // Block arrives on the same edge a buffer frees while both are full.
        do_reset();
        do_start(16, 16);
        drive_block(1'b1, 0, 16, 16);
        drive_block(1'b1, 1, 16, 16);
        repeat (63) @(posedge clk);
        #1;
        chk(blk_full == 1'b1, "same_edge_full_before", blk_full, 1);
        drive_block(1'b0, 2, 16, 16);
        chk(overflow == 1'b1, "same_edge_overflow", overflow, 1);
        chk(blk_full == 1'b0, "same_edge_full_after", blk_full, 0);
        wait_drain(300, "same_edge_drain");
        chk(pix_cnt == 128, "same_edge_pix_count", pix_cnt, 128);

        // Reset in the middle of block 0.
        do_reset();
        do_start(16, 16);
        drive_block(1'b1, 0, 16, 16);
        for (int n = 0; n < 200 && pix_cnt < 30; n++) @(negedge clk);
        chk(pix_cnt >= 30, "reach_pixel30", pix_cnt, 30);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_zero("reset_mid_outputs");
        rst = 1'b0;
        sb.delete(); pix_cnt = 0; fd_cnt = 0;
        drive_block(1'b0, 0, 16, 16);
        repeat (80) @(posedge clk);
        #1;
        chk(overflow == 1'b1, "idle_overflow", overflow, 1);
        chk(pix_cnt == 0, "idle_no_pixels", pix_cnt, 0);
        chk(fd_cnt == 0, "reset_no_frame_done", fd_cnt, 0);

        // Zero-sized start is ignored: block lands in IDLE.
        do_reset();
        do_start(0, 16);
        drive_block(1'b0, 0, 16, 16);
        repeat (10) @(posedge clk);
        #1;
        chk(overflow == 1'b1, "zero_dim_overflow", overflow, 1);
        chk(pix_cnt == 0, "zero_dim_no_pixels", pix_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
